// File: rtl/mux_sweep_pkg.sv
// Shared types and constants for the 8:1 mux sweep checker.
package mux_sweep_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mux_sweep_checker_settle_timer.sv
// Loadable down-counter that paces how long each select row is held.
module settle_timer
    import mux_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over decrement; the count parks at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sweep_checker.sv
// Steps a mux under test through all eight select rows, samples its output
// after a settle delay and scores it against an expected truth table.
module mux_sweep_checker
    import mux_sweep_pkg::*;
#(
    parameter logic [ROWS-1:0] EXP_TABLE = 8'b10010110,
    parameter int unsigned     SETTLE    = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic [SEL_W-1:0] first_err_idx,
    output logic [ROWS-1:0]  captured
);

    // Count reloaded at the start of every row; SETTLE-1 makes a row last
    // SETTLE wait cycles plus the single sample cycle.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(ROWS - 1);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [3:0]       err_count_q;
    logic [SEL_W-1:0] first_err_q;
    logic [ROWS-1:0]  captured_q;

    logic             accept_start;
    logic             row_miss;
    logic [3:0]       err_count_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;

    // Start is honoured only when not sweeping; the compare is evaluated
    // against the row currently driven on sel.
    always_comb begin
        accept_start = start && ((state_q == IDLE) || (state_q == DONE));
        row_miss     = (y_in != EXP_TABLE[sel_q]);
        err_count_d  = row_miss ? (err_count_q + 4'd1) : err_count_q;
        tmr_load     = accept_start || ((state_q == SAMPLE) && (sel_q != LAST_ROW));
        tmr_dec      = (state_q == WAIT);
    end

    settle_timer u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .dec_i   (tmr_dec),
        .value_i (RELOAD),
        .zero_o  (tmr_zero)
    );

    // Sweep FSM with registered status, capture and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
            captured_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_start) begin
                        state_q     <= WAIT;
                        sel_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_count_q <= '0;
                        first_err_q <= '0;
                        captured_q  <= '0;
                    end
                end
                WAIT: begin
                    // y_in is deliberately ignored here so settling glitches
                    // on the mux output never reach the score.
                    if (tmr_zero) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured_q[sel_q] <= y_in;
                    err_count_q       <= err_count_d;
                    if (row_miss && (err_count_q == 4'd0)) begin
                        first_err_q <= sel_q;
                    end
                    if (sel_q == LAST_ROW) begin
                        state_q <= DONE;
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 4'd0);
                    end else begin
                        state_q <= WAIT;
                        sel_q   <= sel_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel           = sel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign captured      = captured_q;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed-vector bench for mux_sweep_checker (SETTLE=1 and SETTLE=3 instances).
module tb_mux_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       y0, y1;
    logic [7:0] model0;

    logic [2:0] sel0, sel1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] errc0, errc1;
    logic [2:0] ferr0, ferr1;
    logic [7:0] cap0, cap1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Mux model for the SETTLE=1 instance: Y follows the driven select.
    always_comb y0 = model0[sel0];

    mux_sweep_checker #(.EXP_TABLE(8'b10010110), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y_in(y0),
        .sel(sel0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(errc0), .first_err_idx(ferr0), .captured(cap0)
    );

    mux_sweep_checker #(.EXP_TABLE(8'b10010110), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y_in(y1),
        .sel(sel1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(errc1), .first_err_idx(ferr1), .captured(cap1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on dut0; returns just after the accepting edge.
    task automatic kick0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    // Runs the 16 post-accept edges of a SETTLE=1 sweep checking sel stepping.
    task automatic run_sweep0(input string tag);
        for (int e = 1; e <= 15; e++) begin
            tick();
            n_vec++;
            if (sel0 !== 3'(e / 2) || done0 !== 1'b0 || busy0 !== 1'b1) begin
                n_err++;
                $display("FAIL %s_step e=%0d: sel=%0d done=%b busy=%b, want sel=%0d done=0 busy=1",
                         tag, e, sel0, done0, busy0, e / 2);
            end
        end
        tick();
    endtask

    task automatic check_result0(input string tag, input logic exp_pass, input logic [3:0] exp_err,
                                 input logic [2:0] exp_first, input logic [7:0] exp_cap);
        n_vec++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== exp_pass || errc0 !== exp_err ||
            ferr0 !== exp_first || cap0 !== exp_cap || sel0 !== 3'd0) begin
            n_err++;
            $display("FAIL %s_result: done=%b busy=%b pass=%b err=%0d first=%0d cap=%h sel=%0d, want done=1 busy=0 pass=%b err=%0d first=%0d cap=%h sel=0",
                     tag, done0, busy0, pass0, errc0, ferr0, cap0, sel0, exp_pass, exp_err, exp_first, exp_cap);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; y1 = 1'b0; model0 = 8'h96;
        #12;
        n_vec++;
        if ({sel0, busy0, done0, pass0, errc0, ferr0, cap0} !== '0 ||
            {sel1, busy1, done1, pass1, errc1, ferr1, cap1} !== '0) begin
            n_err++;
            $display("FAIL reset_state: dut0=%h dut1=%h, want all zero",
                     {sel0, busy0, done0, pass0, errc0, ferr0, cap0},
                     {sel1, busy1, done1, pass1, errc1, ferr1, cap1});
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy0, done0);
        end
    endtask

    task automatic test_ideal();
        model0 = 8'h96;
        kick0();
        n_vec++;
        if (busy0 !== 1'b1 || sel0 !== 3'd0 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL ideal_accept: busy=%b sel=%0d done=%b, want 1 0 0", busy0, sel0, done0);
        end
        run_sweep0("ideal");
        check_result0("ideal", 1'b1, 4'd0, 3'd0, 8'h96);
    endtask

    task automatic test_stuck_low();
        model0 = 8'h00;
        kick0();
        run_sweep0("stuck0");
        check_result0("stuck0", 1'b0, 4'd4, 3'd1, 8'h00);
    endtask

    task automatic test_row5_and_restart();
        model0 = 8'hB6;
        kick0();
        run_sweep0("row5");
        check_result0("row5", 1'b0, 4'd1, 3'd5, 8'hB6);
        // Restart from DONE: results clear on the accepting edge.
        model0 = 8'h96;
        kick0();
        n_vec++;
        if (done0 !== 1'b0 || pass0 !== 1'b0 || busy0 !== 1'b1 || sel0 !== 3'd0 ||
            errc0 !== 4'd0 || cap0 !== 8'h00) begin
            n_err++;
            $display("FAIL restart_clear: done=%b pass=%b busy=%b sel=%0d err=%0d cap=%h, want 0 0 1 0 0 00",
                     done0, pass0, busy0, sel0, errc0, cap0);
        end
        run_sweep0("restart");
        check_result0("restart", 1'b1, 4'd0, 3'd0, 8'h96);
    endtask

    task automatic test_back_to_back();
        model0 = 8'h96;
        start0 = 1'b1;
        tick();
        run_sweep0("held");
        check_result0("held", 1'b1, 4'd0, 3'd0, 8'h96);
        tick();
        n_vec++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || sel0 !== 3'd0) begin
            n_err++;
            $display("FAIL held_restart: done=%b busy=%b sel=%0d, want 0 1 0", done0, busy0, sel0);
        end
        start0 = 1'b0;
        run_sweep0("held2");
        check_result0("held2", 1'b1, 4'd0, 3'd0, 8'h96);
    endtask

    task automatic test_async_reset();
        model0 = 8'h96;
        kick0();
        for (int e = 1; e <= 8; e++) tick();
        n_vec++;
        if (sel0 !== 3'd4) begin
            n_err++;
            $display("FAIL midreset_row: sel=%0d, want 4", sel0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({sel0, busy0, done0, pass0, errc0, ferr0, cap0} !== '0) begin
            n_err++;
            $display("FAIL midreset_clear: outs=%h, want 0", {sel0, busy0, done0, pass0, errc0, ferr0, cap0});
        end
        #3 rst_n = 1'b1;
        tick();
        tick();
        n_vec++;
        if (busy0 !== 1'b0 || sel0 !== 3'd0) begin
            n_err++;
            $display("FAIL midreset_idle: busy=%b sel=%0d, want 0 0", busy0, sel0);
        end
        kick0();
        run_sweep0("postreset");
        check_result0("postreset", 1'b1, 4'd0, 3'd0, 8'h96);
    endtask

    task automatic test_settle3_glitch();
        logic [7:0] tbl;
        logic       tog;
        tbl = 8'h96;
        tog = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) begin
                y1  = (c == 3) ? tbl[r] : tog;
                tog = ~tog;
                n_vec++;
                if (sel1 !== 3'(r) || done1 !== 1'b0 || busy1 !== 1'b1) begin
                    n_err++;
                    $display("FAIL s3_step r=%0d c=%0d: sel=%0d done=%b busy=%b, want sel=%0d done=0 busy=1",
                             r, c, sel1, done1, busy1, r);
                end
                tick();
            end
        end
        n_vec++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || errc1 !== 4'd0 || cap1 !== 8'h96 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL s3_result: done=%b pass=%b err=%0d cap=%h busy=%b, want 1 1 0 96 0",
                     done1, pass1, errc1, cap1, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck_low();
        test_row5_and_restart();
        test_back_to_back();
        test_async_reset();
        test_settle3_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
